// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported unified memory between the fetch stage (imem) and
// the memory-access stage (dmem). Dmem has priority, but after MAX_D_STREAK
// consecutive dmem grants taken while imem was waiting, imem wins the next
// contention. A fetch flush discards the response of an outstanding (or
// same-cycle-granted) fetch without disturbing the memory access itself.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_imem_req/addr      fetch request (held until o_imem_gnt)
//   o_imem_gnt           fetch accepted this cycle (combinational, IDLE only)
//   o_imem_rvalid/rdata  fetch response pulse and instruction word
//   i_imem_flush         discard outstanding / same-cycle-granted fetch data
//   i_dmem_req/addr/wen/wdata/mask   data request (held until o_dmem_gnt)
//   o_dmem_gnt           data request accepted this cycle
//   o_dmem_rvalid/rdata  load data valid or store complete pulse
//   o_mem_addr/ren/wen/wdata/mask    memory port, held stable while busy
//   i_mem_valid/rdata    memory completes the current access
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_gnt,
    output logic        o_imem_rvalid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_imem_flush,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_gnt,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_streak;
    logic        r_flush_pend;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_wen;
    logic        w_pick_i;
    logic        w_pick_d;
    logic        w_unused;

    // Byte-offset bits are dropped: the memory is word-addressed.
    assign w_unused = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

    // Arbitration: grants only in IDLE and never while reset is asserted, so
    // a request seen during reset cannot produce a grant pulse.
    always_comb begin
        w_pick_i = 1'b0;
        w_pick_d = 1'b0;
        if ((r_state == ST_IDLE) && rst_n) begin
            if (i_imem_req && i_dmem_req) begin
                if (r_streak == STREAK_MAX) begin
                    w_pick_i = 1'b1;
                end else begin
                    w_pick_d = 1'b1;
                end
            end else begin
                w_pick_i = i_imem_req;
                w_pick_d = i_dmem_req;
            end
        end else begin
            w_pick_i = 1'b0;
            w_pick_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: completion always returns to IDLE, which enforces one
    // idle cycle between consecutive accesses.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_i) begin
                    w_next_state = ST_BUSY_I;
                end else if (w_pick_d) begin
                    w_next_state = ST_BUSY_D;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (i_mem_valid) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: grants, completion pulses and memory enables.
    always_comb begin
        o_imem_gnt    = w_pick_i;
        o_dmem_gnt    = w_pick_d;
        o_imem_rvalid = 1'b0;
        o_dmem_rvalid = 1'b0;
        o_mem_ren     = 1'b0;
        o_mem_wen     = 1'b0;
        case (r_state)
            ST_BUSY_I: begin
                o_mem_ren = 1'b1;
                // A flush arriving in the completion cycle also discards it.
                if (i_mem_valid && rst_n) begin
                    o_imem_rvalid = ~r_flush_pend & ~i_imem_flush;
                end else begin
                    o_imem_rvalid = 1'b0;
                end
            end
            ST_BUSY_D: begin
                o_mem_ren     = ~r_wen;
                o_mem_wen     = r_wen;
                o_dmem_rvalid = i_mem_valid & rst_n;
            end
            default: begin
                o_mem_ren = 1'b0;
                o_mem_wen = 1'b0;
            end
        endcase
        o_imem_rdata = o_imem_rvalid ? i_mem_rdata : 32'h0000_0000;
        o_dmem_rdata = o_dmem_rvalid ? i_mem_rdata : 32'h0000_0000;
    end

    // Request latch: captured on the accepting edge, held through BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_mask  <= 4'b0000;
            r_wen   <= 1'b0;
        end else if (w_pick_i) begin
            r_addr  <= {i_imem_addr[31:2], 2'b00};
            r_wdata <= 32'h0000_0000;
            r_mask  <= 4'b1111;
            r_wen   <= 1'b0;
        end else if (w_pick_d) begin
            r_addr  <= {i_dmem_addr[31:2], 2'b00};
            r_wdata <= i_dmem_wdata;
            r_mask  <= i_dmem_mask;
            r_wen   <= i_dmem_wen;
        end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
            r_mask  <= r_mask;
            r_wen   <= r_wen;
        end
    end

    // Dmem streak counter: counts dmem wins taken while imem was waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_streak <= 4'd0;
        end else if (w_pick_d) begin
            if (!i_imem_req) begin
                r_streak <= 4'd0;
            end else if (r_streak >= STREAK_MAX) begin
                r_streak <= STREAK_MAX;
            end else begin
                r_streak <= r_streak + 4'd1;
            end
        end else if (w_pick_i) begin
            r_streak <= 4'd0;
        end else begin
            r_streak <= r_streak;
        end
    end

    // Flush-pending flag: marks the current fetch as stale until it completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_flush_pend <= w_pick_i & i_imem_flush;
                ST_BUSY_I: begin
                    if (i_mem_valid) begin
                        r_flush_pend <= 1'b0;
                    end else if (i_imem_flush) begin
                        r_flush_pend <= 1'b1;
                    end else begin
                        r_flush_pend <= r_flush_pend;
                    end
                end
                default: r_flush_pend <= 1'b0;
            endcase
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_mask  = r_mask;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (imem requester) and the memory-access stage (dmem requester) of the pipelined hart.
- Requesters use a req/gnt/rvalid handshake. The memory side is a variable-latency port that holds the request until the memory returns a valid pulse.
- Dmem has priority. A starvation counter guarantees fetch progress. A flush input discards stale fetch responses after a taken branch or jump.

Parameters:
- MAX_D_STREAK, 4, number of consecutive dmem grants allowed while imem is waiting; after that, imem wins the next contention (1..15).

Ports:
- clk  in  1  global clock
- rst_n  in  1  synchronous active-low reset
- i_imem_req  in  1  fetch request; held high until o_imem_gnt
- i_imem_addr  in  32  fetch address
- o_imem_gnt  out  1  fetch request accepted this cycle
- o_imem_rvalid  out  1  one-cycle pulse; o_imem_rdata valid
- o_imem_rdata  out  32  fetched instruction word
- i_imem_flush  in  1  discard any outstanding or same-cycle-granted fetch response
- i_dmem_req  in  1  data request; held high until o_dmem_gnt
- i_dmem_addr  in  32  data address
- i_dmem_wen  in  1  1 = store, 0 = load
- i_dmem_wdata  in  32  store data, already lane-shifted
- i_dmem_mask  in  4  byte-lane mask
- o_dmem_gnt  out  1  data request accepted this cycle
- o_dmem_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- o_dmem_rdata  out  32  load word; don't-care for stores
- o_mem_addr  out  32  word-aligned memory address; bits [1:0] always 0
- o_mem_ren  out  1  memory read enable
- o_mem_wen  out  1  memory write enable; never asserted together with o_mem_ren
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  4  memory byte mask; 4'b1111 for fetches
- i_mem_valid  in  1  memory completes the current access this cycle
- i_mem_rdata  in  32  memory read data, valid with i_mem_valid

Behaviour:
- States:
  - IDLE: no access outstanding.
  - BUSY_I: fetch access outstanding.
  - BUSY_D: data access outstanding.
- Reset (rst_n low at a clock edge):
  - State goes to IDLE, the streak counter to 0, and the flush-pending flag to 0.
  - All outputs are 0 the cycle after reset, including addr, wdata and mask.
  - A reset mid-transaction abandons the access. No rvalid is ever produced for it.
- Grants:
  - o_imem_gnt and o_dmem_gnt are combinational and asserted only in IDLE. At most one is high per cycle.
  - Acceptance at edge T latches addr (bits [1:0] forced to 0), wen, wdata and mask, then moves to BUSY_I or BUSY_D.
- Arbitration in IDLE:
  - Only one requester: that requester is granted.
  - Both request: dmem wins unless streak == MAX_D_STREAK, in which case imem wins.
- Streak counter update:
  - On a dmem grant while i_imem_req = 1: increment, saturating at MAX_D_STREAK.
  - On a dmem grant while i_imem_req = 0: clear.
  - On an imem grant: clear.
- BUSY states:
  - Drive o_mem_* from the latched registers.
  - ren = 1 in BUSY_I, and in BUSY_D with a load. wen = 1 in BUSY_D with a store.
  - Hold all o_mem_* stable until i_mem_valid.
- Completion:
  - The cycle i_mem_valid = 1 in BUSY, the owner's rvalid pulses combinationally, and rdata = i_mem_rdata.
  - The next state is IDLE, so there is one IDLE cycle minimum between accesses. Minimum req-to-rvalid latency is 1 cycle (grant at cycle 0, valid at cycle 1).
- Flush:
  - i_imem_flush in BUSY_I, or in IDLE in the same cycle as an imem grant, sets flush-pending.
  - The memory access still completes, but o_imem_rvalid is suppressed. The flag clears on that completion.
  - A flush in BUSY_D or in IDLE without a grant has no effect.
- i_mem_valid in IDLE is ignored.
- rdata outputs may be held or driven from i_mem_rdata, but are only meaningful with rvalid.
- Requesters dropping req without a grant is legal. The arbiter holds no state for an ungranted request.

Test Plan:
- Reset, then imem req addr 0x0000_1003; memory returns valid after 3 cycles with 0x0000_0013 -> gnt at cycle 0; o_mem_addr = 0x0000_1000, ren = 1, mask = 4'b1111 for cycles 1-3; o_imem_rvalid with rdata 0x0000_0013 at cycle 3.
- Store: dmem addr 0x2000, wen = 1, wdata 0xAB00_0000, mask 4'b1000 -> o_mem_wen = 1, ren = 0, values stable until valid; o_dmem_rvalid pulses once.
- Both requesting continuously, MAX_D_STREAK = 4, memory latency 1 -> grant order D, D, D, D, I, D, D, D, D, I.
- imem granted, i_imem_flush pulsed in BUSY_I, memory valid 2 cycles later -> no o_imem_rvalid; the next fetch returns normally.
- rst_n low mid-BUSY_D with valid arriving during reset -> all outputs 0, state IDLE, no o_dmem_rvalid; the next request is granted normally.
- i_mem_valid pulsed in IDLE with no request outstanding -> no rvalid on either port, state unchanged.
